pipe_regfile: RTL and testbench
===============================

// Module: pipe_regfile
// PURPOSE
//  Parametrised register file for the BRISC pipeline, replacing the fixed
//  16x16, 2-read register array. Adds multi-port reads, write-back-to-read
//  bypass and a per-register pending-write scoreboard.
//  Issue stall is generated in hardware, so back-to-back dependent ops run
//  without NOP padding. Sits between decode/issue and the execute stage;
//  write-back drives its write port.
// PARAMETERS
//  DATA_W    16  register width in bits
//  ADDR_W    4   register address width; NREGS = 2**ADDR_W
//  NUM_RD    2   number of read ports
//  PEND_W    2   scoreboard counter width; PEND_MAX = 2**PEND_W-1 writes in flight per reg
//  ZERO_REG  1   1: r0 reads 0, ignores writes and is never pending
// PORTS
//  CLK          in   1               single clock, rising edge
//  RST_N        in   1               synchronous reset, active-low
//  rd_en        in   NUM_RD          port i read is live (participates in hazard check)
//  rd_addr      in   NUM_RD*ADDR_W   port i address, port 0 in LSBs
//  rd_data      out  NUM_RD*DATA_W   port i data, combinational
//  issue_valid  in   1               decode presents an instruction
//  issue_wr     in   1               that instruction writes a register
//  issue_dst    in   ADDR_W          its destination
//  stall        out  1               issue blocked this cycle; combinational
//  wb_valid     in   1               write-back commit
//  wb_addr      in   ADDR_W          write-back destination
//  wb_data      in   DATA_W          write-back value
//  flush        in   1               discard all in-flight writers (jump taken)
//  sb_err       out  1               sticky: write-back to a non-pending reg, or counter overflow
// BEHAVIOUR
//  Reset: when RST_N=0 at an edge, all regs, counters and sb_err are cleared to 0.
//   rd_data is then 0 for every address.
//  Write: on the edge with wb_valid=1, regs[wb_addr] <= wb_data. Ignored for r0 if ZERO_REG.
//  Read: rd_data[i] = regs[rd_addr[i]], with a bypass. The bypass applies when
//   wb_valid and wb_addr==rd_addr[i] and the address is not r0 (ZERO_REG=1).
//   In that case rd_data[i] = wb_data, giving 0-cycle write-to-read.
//  hz[i] (read hazard on port i) = rd_en[i] & (pend[rd_addr[i]] > dec[rd_addr[i]]).
//   dec[a] = 1 if wb_valid & wb_addr==a, else 0.
//  WAW limit: issue_wr, and pend[issue_dst]==PEND_MAX, and dec[issue_dst]==0.
//  stall = issue_valid & (any hz[i] | WAW limit).
//  Accepted issue = issue_valid & issue_wr & ~stall & ~flush.
//   r0 is excluded when ZERO_REG=1.
//  Counter next-state per reg a:
//   +1 on an accepted issue to a; -1 on dec[a].
//   When both occur on the same reg the counter is unchanged.
//  Underflow: dec on a counter already at 0 leaves it at 0 and sets sb_err.
//   The data write still occurs.
//  flush=1: all counters go to 0 at the next edge, overriding issue and dec.
//   A wb write in the same cycle still updates regs.
//  Latency: scoreboard update takes effect 1 cycle after the edge; reads are 0-cycle.
//  Reset asserted mid-operation: overrides flush, wb and issue in that cycle.
// CONFIGURATION
//  PIPE_REGFILE_BYPASS_EN defined: bypass and dec-credit in hz[] as above.
//  PIPE_REGFILE_BYPASS_EN undefined:
//   - no bypass; rd_data always comes from regs.
//   - hz[i] = rd_en[i] & (pend[rd_addr[i]] != 0), so a dependent read waits
//     one extra cycle after write-back.
//  WAW and counter rules are unchanged in both builds.
// STRUCTURE
//  brisc_pipe_pkg holds shared constants and typedefs:
//   DATA_W/ADDR_W defaults, NREGS, PEND_MAX, and typedefs reg_addr_t, reg_data_t.
//   The processor top, control logic and this block all import it.
//  Sub-module pend_counter: one PEND_W saturating up/down counter with an
//   inc/dec/clr interface and an underflow flag. It is generated NREGS times.
//  Hazard/bypass comparators are a generate loop over NUM_RD.
// TESTING
//  T1 reset: RST_N=0 for 2 cycles, then read all regs -> all rd_data=0, stall=0, sb_err=0.
//  T2 RAW bypass:
//   issue dst=3, then next cycle wb r3=0x1234 with rd_en[0], rd_addr=3
//    -> rd_data[0]=0x1234, stall=0.
//   Same test without the macro -> stall=1 that cycle, 0x1234 read the next cycle.
//  T3 RAW stall:
//   issue dst=5, then read r5 with no wb -> stall=1 each cycle until wb r5.
//   No counter increment happens while stalled.
//  T4 WAW limit: PEND_W=2, three accepted issues to r7 -> pend=3.
//   A 4th issue to r7 -> stall=1.
//   Same cycle with wb r7 -> accepted, pend stays 3.
//  T5 flush: pend r2=2 and r9=1, assert flush with wb r2=0xBEEF.
//   -> next cycle all pend=0 and regs[2]=0xBEEF; the issue in the flush cycle is dropped.
//  T6 zero/underflow:
//   wb r0=0xFFFF -> r0 reads 0.
//   wb r4 with pend=0 -> regs[4] written, sb_err=1 and it stays set until reset.

Source files
------------

// File: rtl/pipe_regfile_pkg.sv
// Shared BRISC pipeline constants and register typedefs for the register file.
package pipe_regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 4;
    localparam int unsigned DEF_NUM_RD   = 2;
    localparam int unsigned DEF_PEND_W   = 2;
    localparam int unsigned DEF_NREGS    = 32'(1) << DEF_ADDR_W;
    localparam int unsigned DEF_PEND_MAX = (32'(1) << DEF_PEND_W) - 1;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

    // Largest value a w-bit counter can hold.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'(1) << w) - 1;
    endfunction

endpackage

// File: rtl/pipe_regfile_if.sv
// Issue / read / write-back bus between decode, write-back and the register file.
interface pipe_regfile_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_RD = 2
);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     issue_valid;
    logic                     issue_wr;
    logic [ADDR_W-1:0]        issue_dst;
    logic                     stall;
    logic                     wb_valid;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     flush;
    logic                     sb_err;

    modport master (
        output rd_en, rd_addr, issue_valid, issue_wr, issue_dst,
               wb_valid, wb_addr, wb_data, flush,
        input  rd_data, stall, sb_err
    );

    modport slave (
        input  rd_en, rd_addr, issue_valid, issue_wr, issue_dst,
               wb_valid, wb_addr, wb_data, flush,
        output rd_data, stall, sb_err
    );

endinterface

// File: rtl/pipe_regfile_pend_counter.sv
// Per-register pending-write counter: saturating up/down with clear and error flag.
module pipe_regfile_pend_counter
    import pipe_regfile_pkg::*;
#(
    parameter int unsigned PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              err_c
);

    localparam logic [PEND_W-1:0] MAX = PEND_W'(cnt_max(PEND_W));

    // Underflow (dec at zero) or overflow (lone inc at max); clear suppresses both.
    assign err_c = !clr && ((dec && cnt == '0) || (inc && !dec && cnt == MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != MAX) begin
            cnt <= cnt + PEND_W'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - PEND_W'(1);
        end
    end

endmodule

// File: rtl/pipe_regfile.sv
// BRISC register file with multi-port reads, write-back bypass and pending-write scoreboard.
// Build option: PIPE_REGFILE_BYPASS_EN enables write-back-to-read bypass and dec credit in hazards.
module pipe_regfile
    import pipe_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter int unsigned PEND_W   = DEF_PEND_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic           CLK,
    input  logic           RST_N,
    pipe_regfile_if.slave  bus
);

    localparam int unsigned NREGS = 32'(1) << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(cnt_max(PEND_W));

    logic [DATA_W-1:0] regs    [NREGS];
    logic [PEND_W-1:0] pend    [NREGS];
    logic [DATA_W-1:0] rd_word [NUM_RD];
    logic [NREGS-1:0]  dec_c;
    logic [NREGS-1:0]  inc_c;
    logic [NREGS-1:0]  err_vec_c;
    logic [NUM_RD-1:0] hz_c;
    logic              waw_c;
    logic              stall_c;
    logic              accept_c;
    logic              dst_is_zero_c;
    logic              wb_is_zero_c;
    logic              sb_err_q;

    assign dst_is_zero_c = ZERO_REG && bus.issue_dst == '0;
    assign wb_is_zero_c  = ZERO_REG && bus.wb_addr == '0;

    // Per-register retire (dec) and accepted-issue (inc) strobes.
    always_comb begin
        dec_c = '0;
        inc_c = '0;
        for (int unsigned a = 0; a < NREGS; a++) begin
            dec_c[a] = bus.wb_valid && !wb_is_zero_c && bus.wb_addr == ADDR_W'(a);
            inc_c[a] = accept_c && bus.issue_dst == ADDR_W'(a);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef PIPE_REGFILE_BYPASS_EN
        assign rd_word[i] = dec_c[a] ? bus.wb_data : regs[a];
        assign hz_c[i]    = bus.rd_en[i] && (pend[a] > PEND_W'(dec_c[a]));
`else
        assign rd_word[i] = regs[a];
        assign hz_c[i]    = bus.rd_en[i] && (pend[a] != '0);
`endif
    end

    always_comb begin
        bus.rd_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = rd_word[i];
        end
    end

    assign waw_c    = bus.issue_wr && pend[bus.issue_dst] == PEND_MAX && !dec_c[bus.issue_dst];
    assign stall_c  = bus.issue_valid && ((|hz_c) || waw_c);
    assign accept_c = bus.issue_valid && bus.issue_wr && !stall_c && !bus.flush && !dst_is_zero_c;
    assign bus.stall = stall_c;

    for (genvar r = 0; r < NREGS; r++) begin : g_pend
        pipe_regfile_pend_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk   (CLK),
            .rst_n (RST_N),
            .inc   (inc_c[r]),
            .dec   (dec_c[r]),
            .clr   (bus.flush),
            .cnt   (pend[r]),
            .err_c (err_vec_c[r])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int unsigned a = 0; a < NREGS; a++) begin
                regs[a] <= '0;
            end
        end else if (bus.wb_valid && !wb_is_zero_c) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Sticky scoreboard error, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sb_err_q <= 1'b0;
        end else if (|err_vec_c) begin
            sb_err_q <= 1'b1;
        end
    end

    assign bus.sb_err = sb_err_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// Scoreboard bench for pipe_regfile: directed scenarios then random traffic vs a reference model.
module tb_pipe_regfile;

`ifdef PIPE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int PMAX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_regfile_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) bus ();

    pipe_regfile #(
        .DATA_W(16), .ADDR_W(4), .NUM_RD(2), .PEND_W(2), .ZERO_REG(1'b1)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    logic [15:0] m_regs [16];
    int          m_pend [16];
    bit          m_err;
    bit          m_valid = 1'b0;

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (bus.rd_data[15:0] !== e.d0) begin
                n_bad++;
                $display("FAIL rd_data0 vec %0d: got %h want %h", n_vec, bus.rd_data[15:0], e.d0);
            end
            if (bus.rd_data[31:16] !== e.d1) begin
                n_bad++;
                $display("FAIL rd_data1 vec %0d: got %h want %h", n_vec, bus.rd_data[31:16], e.d1);
            end
            if (bus.stall !== e.stall) begin
                n_bad++;
                $display("FAIL stall vec %0d: got %b want %b", n_vec, bus.stall, e.stall);
            end
            if (bus.sb_err !== e.err) begin
                n_bad++;
                $display("FAIL sb_err vec %0d: got %b want %b", n_vec, bus.sb_err, e.err);
            end
        end
    end

    function automatic bit retires(input logic wv, input logic [3:0] wa, input int a);
        return wv && wa != 4'd0 && int'(wa) == a;
    endfunction

    // One clock of stimulus: drive, record the expected response, advance the model.
    task automatic step(input bit rst, input logic [1:0] ren, input logic [3:0] a0,
                        input logic [3:0] a1, input bit iv, input bit iw,
                        input logic [3:0] dst, input bit wv, input logic [3:0] wa,
                        input logic [15:0] wd, input bit fl);
        logic [3:0] ad [2];
        logic [15:0] dd [2];
        bit hz, waw, stl, acc, dwa;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = ~rst;
        bus.rd_en       = ren;
        bus.rd_addr     = {a1, a0};
        bus.issue_valid = iv;
        bus.issue_wr    = iw;
        bus.issue_dst   = dst;
        bus.wb_valid    = wv;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
        bus.flush       = fl;
        ad[0] = a0;
        ad[1] = a1;
        hz = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit d;
            d = retires(wv, wa, int'(ad[i]));
            dd[i] = (BYP && d) ? wd : m_regs[ad[i]];
            if (ren[i]) begin
                if (BYP) hz |= m_pend[ad[i]] > (d ? 1 : 0);
                else     hz |= m_pend[ad[i]] != 0;
            end
        end
        waw = iw && m_pend[dst] == PMAX && !retires(wv, wa, int'(dst));
        stl = iv && (hz || waw);
        if (m_valid) begin
            e.d0 = dd[0]; e.d1 = dd[1]; e.stall = stl; e.err = m_err;
            q.push_back(e);
        end
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 0;
            end
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (wv && wa != 4'd0) m_regs[wa] = wd;
            if (fl) begin
                for (int r = 0; r < 16; r++) m_pend[r] = 0;
            end else begin
                acc = iv && iw && !stl && dst != 4'd0;
                dwa = wv && wa != 4'd0;
                if (dwa && m_pend[wa] == 0) m_err = 1'b1;
                if (acc && dwa && dst == wa) begin
                    // issue and retire on the same register cancel out
                end else begin
                    if (dwa && m_pend[wa] > 0) m_pend[wa]--;
                    if (acc) begin
                        if (m_pend[dst] == PMAX) m_err = 1'b1;
                        else m_pend[dst]++;
                    end
                end
            end
        end
    endtask

    task automatic idle();
        step(0, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 16'h0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pick;
        logic [3:0] wa;
        bus.rd_en = '0; bus.rd_addr = '0; bus.issue_valid = 0; bus.issue_wr = 0;
        bus.issue_dst = '0; bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.flush = 0;

        // Reset for two cycles, then every register reads zero.
        step(1, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 16'h0, 0);
        step(1, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 16'h0, 0);
        for (int r = 0; r < 16; r++)
            step(0, 2'b00, 4'(r), 4'(15 - r), 0, 0, 4'd0, 0, 4'd0, 16'h0, 0);

        // RAW through write-back.
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd3, 0, 4'd0, 16'h0, 0);
        step(0, 2'b01, 4'd3, 4'd0, 1, 0, 4'd0, 1, 4'd3, 16'h1234, 0);
        step(0, 2'b01, 4'd3, 4'd0, 1, 0, 4'd0, 0, 4'd0, 16'h0, 0);

        // RAW stall until write-back; stalled writer to r6 must not count.
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd5, 0, 4'd0, 16'h0, 0);
        repeat (3) step(0, 2'b01, 4'd5, 4'd0, 1, 1, 4'd6, 0, 4'd0, 16'h0, 0);
        step(0, 2'b01, 4'd5, 4'd0, 1, 0, 4'd0, 1, 4'd5, 16'h5555, 0);
        step(0, 2'b01, 4'd5, 4'd0, 1, 0, 4'd0, 0, 4'd0, 16'h0, 0);

        // WAW limit on r7.
        repeat (3) step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd7, 0, 4'd0, 16'h0, 0);
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd7, 0, 4'd0, 16'h0, 0);
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd7, 1, 4'd7, 16'h7777, 0);
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd7, 0, 4'd0, 16'h0, 0);

        // Flush with concurrent write-back and a dropped issue.
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd2, 0, 4'd0, 16'h0, 0);
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd2, 0, 4'd0, 16'h0, 0);
        step(0, 2'b00, 4'd0, 4'd0, 1, 1, 4'd9, 0, 4'd0, 16'h0, 0);
        step(0, 2'b11, 4'd2, 4'd9, 1, 1, 4'd4, 1, 4'd2, 16'hBEEF, 1);
        step(0, 2'b11, 4'd2, 4'd9, 1, 1, 4'd7, 0, 4'd0, 16'h0, 0);
        step(0, 2'b11, 4'd7, 4'd0, 1, 0, 4'd0, 1, 4'd7, 16'hAAAA, 0);

        // r0 ignores writes; write-back to an idle register raises sticky error.
        step(0, 2'b01, 4'd0, 4'd0, 0, 0, 4'd0, 1, 4'd0, 16'hFFFF, 0);
        step(0, 2'b11, 4'd0, 4'd4, 1, 1, 4'd0, 1, 4'd4, 16'h4444, 0);
        repeat (3) idle();
        step(0, 2'b11, 4'd0, 4'd4, 1, 0, 4'd0, 0, 4'd0, 16'h0, 1);

        // Random traffic with occasional flush and reset.
        step(1, 2'b00, 4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 16'h0, 0);
        for (int n = 0; n < 600; n++) begin
            wa = 4'($urandom_range(0, 15));
            pick = int'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 9) < 9 && m_pend[(pick + k) % 16] != 0) begin
                    wa = 4'((pick + k) % 16);
                    break;
                end
            end
            step($urandom_range(0, 99) < 2,
                 2'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 4'($urandom),
                 $urandom_range(0, 2) != 0, wa, 16'($urandom),
                 $urandom_range(0, 99) < 4);
        end

        for (int t = 0; t < 5 && q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
